// File: rtl/datapath_pkg.sv
// Constants and types shared by the uplink and downlink datapath FIFOs.
// Covers the word/beat geometry and the uplink unpacking state machine.
package datapath_pkg;

  localparam int IN_WIDTH  = 192;
  localparam int OUT_WIDTH = 128;
  localparam int PAD_WIDTH = 2 * OUT_WIDTH - IN_WIDTH;

  // Bit ranges of the two beats within one datapath word
  localparam int BEAT0_LO = 0;
  localparam int BEAT0_HI = 127;
  localparam int BEAT1_LO = 128;
  localparam int BEAT1_HI = 191;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BEAT0 = 2'd2,
    BEAT1 = 2'd3
  } uplink_state_t;

endpackage

// File: rtl/datapath_sdp_ram.sv
// Simple dual-port RAM: one write port and one read port with a registered
// read (1-cycle latency). Contents are never reset.
module datapath_sdp_ram #(
  parameter int WIDTH      = 192,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/datapath_uplink_fifo.sv
// Uplink FIFO: buffers 192-bit datapath words and unpacks each one into two
// 128-bit stream beats, the second flagged with m_last.
module datapath_uplink_fifo
  import datapath_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DEPTH_SIZE = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   data_in,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [DEPTH_SIZE:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  threshold,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [15:0]           drop_count
);

  logic [DEPTH_SIZE:0]   w_ptr_reg;
  logic [DEPTH_SIZE:0]   r_ptr_reg;
  logic [DEPTH_SIZE:0]   count_reg;
  logic [IN_WIDTH-1:0]   hold_reg;
  logic [IN_WIDTH-1:0]   rd_data;
  logic                  overflow_reg;
  logic [15:0]           drop_count_reg;
  uplink_state_t         state_reg;
  uplink_state_t         state_next;
  logic                  wr_en;
  logic                  drop;
  logic                  rd_issue;

  // The MSB of each pointer is a wrap bit that separates full from empty
  assign full  = (w_ptr_reg[DEPTH_SIZE] != r_ptr_reg[DEPTH_SIZE]) &&
                 (w_ptr_reg[DEPTH_SIZE-1:0] == r_ptr_reg[DEPTH_SIZE-1:0]);
  assign empty = (w_ptr_reg == r_ptr_reg);

  assign wr_en = in_valid & ~full;
  assign drop  = in_valid & full;

  always_comb begin
    state_next = state_reg;
    rd_issue   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          rd_issue   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = BEAT0;
      BEAT0: begin
        if (m_ready) begin
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        if (m_ready) begin
          if (!empty) begin
            rd_issue   = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  datapath_sdp_ram #(
    .WIDTH      (IN_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (DEPTH_SIZE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (w_ptr_reg[DEPTH_SIZE-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_issue),
    .rd_addr (r_ptr_reg[DEPTH_SIZE-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      w_ptr_reg      <= '0;
      r_ptr_reg      <= '0;
      count_reg      <= '0;
      hold_reg       <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (wr_en) begin
        w_ptr_reg <= w_ptr_reg + 1'b1;
      end
      if (rd_issue) begin
        r_ptr_reg <= r_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_issue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (state_reg == FETCH) begin
        hold_reg <= rd_data;
      end
      // A clear wins over a drop in the same cycle; that drop goes uncounted
      if (clear_overflow) begin
        overflow_reg   <= 1'b0;
        drop_count_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
    end
  end

  assign m_valid    = (state_reg == BEAT0) || (state_reg == BEAT1);
  assign m_last     = (state_reg == BEAT1);
  assign m_data     = (state_reg == BEAT1) ?
                      {{PAD_WIDTH{1'b0}}, hold_reg[BEAT1_HI:BEAT1_LO]} :
                      hold_reg[BEAT0_HI:BEAT0_LO];
  assign data_count = count_reg;
  assign threshold  = (count_reg >= (DEPTH_SIZE + 1)'(DEPTH / 2));
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_datapath_uplink_fifo.sv
// Scoreboard bench for datapath_uplink_fifo at DEPTH=16: expected beats are
// queued when words are written and popped as the stream interface hands them off.
module tb_datapath_uplink_fifo;

  localparam int DEPTH      = 16;
  localparam int DEPTH_SIZE = 4;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic [191:0]       data_in;
  logic [127:0]       m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic [DEPTH_SIZE:0] data_count;
  logic               full;
  logic               empty;
  logic               threshold;
  logic               overflow;
  logic               clear_overflow;
  logic [15:0]        drop_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [128:0] sb [$];
  logic         prev_stall = 1'b0;
  logic [128:0] prev_beat  = '0;
  logic         wr_done;

  datapath_uplink_fifo #(
    .DEPTH      (DEPTH),
    .DEPTH_SIZE (DEPTH_SIZE)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .data_count     (data_count),
    .full           (full),
    .empty          (empty),
    .threshold      (threshold),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [191:0] observed,
                             input logic [191:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [191:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the capturing edge
  task automatic write_word(input logic [191:0] w, input bit dropped);
    in_valid = 1'b1;
    data_in  = w;
    if (!dropped) begin
      sb.push_back({1'b0, w[127:0]});
      sb.push_back({1'b1, 64'h0, w[191:128]});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("write %h%s", w, dropped ? " (expect drop)" : "");
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !m_valid && empty) done = 1'b1;
    end
    check_value(tag, 192'(done), 192'(1'b1));
  endtask

  // Handshakes are judged at the falling edge, ahead of the rising edge that completes them
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_value("stall_valid", 192'(m_valid), 192'(1'b1));
        check_value("stall_beat", 192'({m_last, m_data}), 192'(prev_beat));
      end
      if (m_valid && m_ready) begin
        check_value("sb_nonempty", 192'(sb.size() != 0), 192'(1'b1));
        if (sb.size() != 0) begin
          logic [128:0] exp_beat;
          exp_beat = sb.pop_front();
          check_value("beat", 192'({m_last, m_data}), 192'(exp_beat));
          $display("beat last=%0d data=%h", m_last, m_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  initial begin
    logic [191:0] w;
    int budget;

    rstn = 1'b0; in_valid = 1'b0; data_in = '0; m_ready = 1'b0; clear_overflow = 1'b0;
    wr_done = 1'b0;
    #12;
    check_value("rst_valid", 192'(m_valid), 192'(1'b0));
    check_value("rst_last", 192'(m_last), 192'(1'b0));
    check_value("rst_data", 192'(m_data), 192'(0));
    check_value("rst_empty", 192'(empty), 192'(1'b1));
    check_value("rst_full", 192'(full), 192'(1'b0));
    check_value("rst_count", 192'(data_count), 192'(0));
    check_value("rst_thresh", 192'(threshold), 192'(1'b0));
    check_value("rst_ovf", 192'(overflow), 192'(1'b0));
    check_value("rst_drops", 192'(drop_count), 192'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1);

    // Single word: first beat two cycles after the FIFO becomes non-empty
    m_ready = 1'b1;
    w = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333};
    write_word(w, 1'b0);
    check_value("w0_empty", 192'(empty), 192'(1'b0));
    check_value("w0_count", 192'(data_count), 192'(1));
    check_value("w0_valid_c0", 192'(m_valid), 192'(1'b0));
    step(1);
    check_value("w0_valid_c1", 192'(m_valid), 192'(1'b0));
    check_value("w0_count_c1", 192'(data_count), 192'(0));
    step(1);
    check_value("w0_valid_c2", 192'(m_valid), 192'(1'b1));
    check_value("w0_last_c2", 192'(m_last), 192'(1'b0));
    wait_drain("w0_drain", 20);
    check_value("w0_end_count", 192'(data_count), 192'(0));

    // Fill to full while stalled, then a dropped word and clear_overflow
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(rand_word(), 1'b0);
    step(3);
    check_value("fill_count15", 192'(data_count), 192'(15));
    check_value("fill_notfull", 192'(full), 192'(1'b0));
    write_word(rand_word(), 1'b0);
    check_value("fill_count16", 192'(data_count), 192'(16));
    check_value("fill_full", 192'(full), 192'(1'b1));
    check_value("fill_thresh", 192'(threshold), 192'(1'b1));
    write_word(rand_word(), 1'b1);
    check_value("drop_ovf", 192'(overflow), 192'(1'b1));
    check_value("drop_cnt", 192'(drop_count), 192'(1));
    check_value("drop_count16", 192'(data_count), 192'(16));
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    check_value("clr_ovf", 192'(overflow), 192'(1'b0));
    check_value("clr_cnt", 192'(drop_count), 192'(0));
    clear_overflow = 1'b1;
    write_word(rand_word(), 1'b1);
    clear_overflow = 1'b0;
    check_value("clr_prio_ovf", 192'(overflow), 192'(1'b0));
    check_value("clr_prio_cnt", 192'(drop_count), 192'(0));
    m_ready = 1'b1;
    wait_drain("fill_drain", 300);

    // Write and read issue in the same cycle at data_count=8
    m_ready = 1'b0;
    write_word(rand_word(), 1'b0);
    step(2);
    for (int i = 0; i < 8; i++) write_word(rand_word(), 1'b0);
    check_value("c8_count", 192'(data_count), 192'(8));
    check_value("c8_thresh", 192'(threshold), 192'(1'b1));
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check_value("c8_in_beat1", 192'(m_last), 192'(1'b1));
    m_ready = 1'b1;
    write_word(rand_word(), 1'b0);
    m_ready = 1'b0;
    check_value("c8_simul_count", 192'(data_count), 192'(8));
    step(2);
    m_ready = 1'b1;
    step(1);
    check_value("c8_in_beat1b", 192'(m_last), 192'(1'b1));
    step(1);
    m_ready = 1'b0;
    check_value("c7_count", 192'(data_count), 192'(7));
    check_value("c7_thresh", 192'(threshold), 192'(1'b0));
    m_ready = 1'b1;
    wait_drain("c8_drain", 200);

    // Random backpressure over 40 words
    wr_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          budget = 0;
          while (data_count >= 12 && budget < 200) begin
            step(1);
            budget++;
          end
          write_word(rand_word(), 1'b0);
          step($urandom_range(0, 2));
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          m_ready = 1'($urandom_range(0, 1));
          step(1);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain("bp_drain", 400);

    // Wrap: three passes through the pointer space at one word per 4 cycles
    m_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      write_word(rand_word(), 1'b0);
      for (int j = 0; j < 3; j++) begin
        check_value("wrap_count_le1", 192'(data_count <= 1), 192'(1'b1));
        step(1);
      end
    end
    wait_drain("wrap_drain", 50);

    // Reset during BEAT1 with five words stored
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(rand_word(), 1'b0);
    step(3);
    check_value("rst5_count", 192'(data_count), 192'(5));
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    check_value("rst5_beat1", 192'(m_last), 192'(1'b1));
    rstn = 1'b0;
    sb.delete();
    #1;
    check_value("rst5_valid", 192'(m_valid), 192'(1'b0));
    check_value("rst5_empty", 192'(empty), 192'(1'b1));
    check_value("rst5_cnt", 192'(data_count), 192'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    step(1);
    m_ready = 1'b1;
    write_word(rand_word(), 1'b0);
    write_word(rand_word(), 1'b0);
    wait_drain("post_rst_drain", 50);
    check_value("post_rst_count", 192'(data_count), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/datapath_uplink_fifo.md
Name: datapath_uplink_fifo

Overview:
Reverse-direction companion to the downlink datapath FIFO. It accepts paced 192-bit datapath words and buffers them. Each word is unpacked into two 128-bit beats for the host/DMA stream interface, so the host sees the same 2-beat framing the downlink side consumes. It sits between the datapath sample capture and the host uplink stream.

Parameters:
IN_WIDTH, 192, input word width; fixed, other values unsupported
OUT_WIDTH, 128, output beat width; fixed
DEPTH, 1024, number of 192-bit entries; power of two
DEPTH_SIZE, 10, log2(DEPTH)

Ports:
clk  in  1  single clock, all logic on rising edge
rstn  in  1  reset, asynchronous, active-low
in_valid  in  1  single-cycle strobe; data_in captured when in_valid=1
data_in  in  192  datapath word
m_data  out  128  output beat
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts beat when m_valid & m_ready
m_last  out  1  high on second beat of a word
data_count  out  DEPTH_SIZE+1  stored entries, 0..DEPTH; excludes the word held in the output stage
full  out  1  data_count==DEPTH (combinational from pointers)
empty  out  1  data_count==0 (combinational from pointers)
threshold  out  1  data_count >= DEPTH/2
overflow  out  1  sticky: a write was dropped
clear_overflow  in  1  clears overflow and drop_count
drop_count  out  16  number of dropped words, saturating at 16'hFFFF

Behaviour:
- Async reset (rstn=0) clears pointers, FSM->IDLE, m_valid=0, m_last=0, m_data=0, hold reg=0, overflow=0, drop_count=0, data_count=0, empty=1, full=0, threshold=0. Memory contents are not reset.
- Pointers: w_ptr/r_ptr are DEPTH_SIZE+1 bits; the MSB is the wrap bit.
  - full = wrap bits differ and low bits equal.
  - empty = pointers fully equal.
- Write: if in_valid & ~full, then mem[w_ptr] <= data_in and w_ptr++.
  - If in_valid & full, drop the word, set overflow=1 and increment drop_count (saturating).
  - full is evaluated on the current cycle's state; a same-cycle read does not free space for that write.
- clear_overflow has priority over a same-cycle drop: both flags clear and that drop is not counted.
- data_count is registered: +1 on write, -1 on read issue, unchanged if both occur in the same cycle.
- Memory is simple dual-port with registered read, 1-cycle latency.
- FSM states:
  - IDLE: if ~empty, issue read (r_ptr++) -> FETCH.
  - FETCH: latch memory output into 192-bit hold reg; -> BEAT0.
  - BEAT0: m_valid=1, m_last=0, m_data=hold[127:0]. On m_ready -> BEAT1.
  - BEAT1: m_valid=1, m_last=1, m_data={64'h0, hold[191:128]}. On m_ready: if ~empty, issue read -> FETCH; else -> IDLE.
- Timing: first beat appears 2 cycles after the FIFO becomes non-empty. With m_ready held high, minimum spacing is one word per 3 cycles.
- AXI-stream rule: m_data and m_last are stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake, except on reset.
- A write and a read issue in the same cycle touch different addresses, because a read only issues when non-empty and a write is blocked when full.
- Pointer wrap-around at DEPTH is natural binary wrap with no special case.
- Reset asserted mid-word aborts the current beat pair; any partially sent word is lost.

Decomposition:
- Shared package datapath_pkg holds:
  - IN_WIDTH/OUT_WIDTH constants
  - beat slice constants: BEAT0 = [127:0], BEAT1 = [191:128]
  - uplink FSM state enum: IDLE, FETCH, BEAT0, BEAT1
- One sub-module: datapath_sdp_ram (parameterised width/depth, one write port, one registered read port). It is reusable by the downlink FIFO.

Test Plan:
- Reset, then write W0=192'h1111..._2222..._3333... with m_ready=1 -> beat0=W0[127:0], m_last=0; beat1={64'h0,W0[191:128]}, m_last=1; first beat 2 cycles after write; then empty=1, data_count=0.
- DEPTH=16 bench, 16 writes with m_ready=0 -> after the FIFO drains one word into the hold reg, refill to full=1 and data_count=16. A 17th write gives overflow=1, drop_count=1, and the dropped word never appears. Pulse clear_overflow -> overflow=0, drop_count=0.
- Backpressure: toggle m_ready randomly over 40 words -> beats in order, m_data/m_last stable while stalled, no loss or duplication.
- Wrap: stream 3*DEPTH words through with in_valid every 4 cycles and m_ready=1 -> all words received in order; data_count never exceeds 1.
- Simultaneous write and read issue at data_count=8 -> data_count stays 8; threshold=1 at count 8 and 0 at count 7.
- Assert rstn=0 during BEAT1 with 5 stored words -> immediately m_valid=0, empty=1, data_count=0. After release, the FIFO accepts new words normally.
